norflash_prefetch: RTL
======================

// Module: norflash_prefetch
// PURPOSE
//  One-line read cache / prefetch buffer between the CPU-side Wishbone bus and the
//  16-bit NOR flash controller (a Wishbone slave whose 32-bit reads cost two flash cycles).
//  On a read miss it fetches the whole aligned line with 32-bit reads, then serves hits
//  from the buffer. Writes pass straight through (flash command sequences) and invalidate the line.
// PARAMETERS
//  LINE_LOG2   2    log2(words per line); line = 2**LINE_LOG2 32-bit words (default 16 bytes)
// PORTS
//  sys_clk        in   1   system clock
//  sys_rst_n      in   1   asynchronous active-low reset
//  s_wb_adr_i     in   32  slave byte address (CPU side)
//  s_wb_dat_i     in   32  slave write data
//  s_wb_dat_o     out  32  slave read data
//  s_wb_sel_i     in   4   slave byte selects
//  s_wb_stb_i     in   1   slave strobe
//  s_wb_cyc_i     in   1   slave cycle
//  s_wb_we_i      in   1   slave write enable
//  s_wb_ack_o     out  1   slave ack, single-cycle pulse
//  m_wb_adr_o     out  32  master address to flash controller
//  m_wb_dat_o     out  32  master write data
//  m_wb_dat_i     in   32  master read data
//  m_wb_sel_o     out  4   master byte selects
//  m_wb_stb_o     out  1   master strobe
//  m_wb_cyc_o     out  1   master cycle
//  m_wb_we_o      out  1   master write enable
//  m_wb_ack_i     in   1   master ack
//  flush          in   1   one-cycle pulse: invalidate the line
// BEHAVIOUR
//  - Clocking: one clock; reset is asynchronous and active-low.
//  - Reset values: all outputs 0; valid=0; state=IDLE; fill counter 0.
//  - Tag = s_wb_adr_i[31:LINE_LOG2+2]. Hit = valid & tag match & ~we.
//  - FSM states: IDLE, FILL, WRITE, ACK.
//  - IDLE, cyc&stb&~we, hit: s_wb_dat_o <= line[adr[LINE_LOG2+1:2]]; go to ACK.
//    Ack is seen 1 cycle after stb is sampled. Full word is returned for every sel
//    value; byte lanes are naturally correct.
//  - IDLE, read miss: latch tag; clear valid; word index k=0; go to FILL.
//  - FILL: m_cyc=m_stb=1, m_we=0, m_sel=4'b1111, m_adr={tag,k,2'b00}.
//    On m_ack_i: line[k] <= m_wb_dat_i; k++.
//    - Hold stb low for exactly one cycle after each ack (the controller needs a
//      return to its idle state), then reassert for the next k.
//    - After the last word: valid <= ~flush_pend; load s_wb_dat_o from the requested
//      word; go to ACK.
//  - IDLE, write: copy adr/dat/sel to the master port; m_we=1; clear valid; go to WRITE.
//    On m_ack_i: drop master signals; go to ACK.
//  - ACK: s_wb_ack_o=1 for one cycle; go to IDLE. The next request is sampled no
//    earlier than the cycle after ack.
//  - flush:
//    - In IDLE/ACK: valid <= 0 next cycle.
//    - During FILL: set flush_pend. The fill completes (the controller cannot abort)
//      and the requester is served, but valid stays 0. flush_pend clears on exit.
//  - Slave drops cyc mid-FILL/WRITE: the master transaction still completes; the
//    ack is suppressed if cyc is low in ACK.
//  - Address wrap: the fill counter wraps within the line; it never crosses the
//    line boundary. The top line (0xFFFFFFF0) has no special case.
//  - sys_rst_n low mid-fill: master cyc/stb drop immediately (async); the line is invalid.
// CONFIGURATION
//  - NORFLASH_PREFETCH_STATS_EN defined: adds two ports, hit_count and miss_count
//    (out, 32 each). Each increments once per served read hit or miss, wraps at
//    2**32, and resets to 0.
//  - Not defined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  - Read 0x00000104 after reset -> master reads 0x100,0x104,0x108,0x10C (sel 1111);
//    s_dat = word@0x104; then a read of 0x10C acks 1 cycle later with no master cycle.
//  - Read 0x200 then 0x300 -> second access misses; master refills 0x300..0x30C;
//    a read of 0x200 misses again.
//  - Write 0x0000AAAA to 0x154 sel 0011 after a fill of 0x150 -> master write with
//    identical adr/dat/sel; the next read of 0x150 refetches.
//  - flush pulsed during the 2nd fill word of 0x400 -> requester still gets correct
//    data; the following read of 0x404 misses.
//  - Byte read sel 0100 at 0x109 on a hit line -> s_dat = full word@0x108; ack 1 cycle.
//  - sys_rst_n asserted mid-fill -> m_cyc/m_stb 0 immediately; after release, a read
//    of the same address misses.

Source files
------------

// File: rtl/norflash_prefetch.sv
// One-line read prefetch buffer between a CPU Wishbone port and a 16-bit NOR flash controller.
// Define NORFLASH_PREFETCH_STATS_EN to add the hit_count / miss_count ports.
module norflash_prefetch #(
  parameter int unsigned LINE_LOG2 = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_stb_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_we_i,
  output logic        s_wb_ack_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_we_o,
  input  logic        m_wb_ack_i,
`ifdef NORFLASH_PREFETCH_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        flush
);

  localparam int unsigned WORDS = 1 << LINE_LOG2;
  localparam int unsigned IDX_W = LINE_LOG2;
  localparam int unsigned TAG_W = 32 - LINE_LOG2 - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic               flush_pend_q, flush_pend_d;
  logic               gap_q, gap_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [31:0]        s_dat_q, s_dat_d;
  logic               s_ack_q, s_ack_d;
  logic [31:0]        m_adr_q, m_adr_d;
  logic [31:0]        m_dat_q, m_dat_d;
  logic [3:0]         m_sel_q, m_sel_d;
  logic               m_stb_q, m_stb_d;
  logic               m_cyc_q, m_cyc_d;
  logic               m_we_q, m_we_d;
  logic               line_we_c;
  logic               hit_inc_c, miss_inc_c;
  logic [31:0]        line_q [WORDS];

  logic               req_c, hit_c, last_c, mack_c;
  logic [TAG_W-1:0]   req_tag_c;
  logic [IDX_W-1:0]   req_idx_c;

  assign req_c     = s_wb_cyc_i & s_wb_stb_i;
  assign req_tag_c = s_wb_adr_i[31:LINE_LOG2+2];
  assign req_idx_c = s_wb_adr_i[LINE_LOG2+1:2];
  assign hit_c     = valid_q & (tag_q == req_tag_c) & ~s_wb_we_i;
  assign last_c    = (k_q == IDX_W'(WORDS - 1));
  assign mack_c    = m_wb_ack_i & m_stb_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          if (s_wb_we_i)  state_d = WRITE;
          else if (hit_c) state_d = ACK;
          else            state_d = FILL;
        end
      end
      FILL:    if (mack_c && last_c) state_d = ACK;
      WRITE:   if (m_wb_ack_i) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the ack is suppressed when the requester has already dropped cyc.
  always_comb begin
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    gap_d        = gap_q;
    tag_d        = tag_q;
    k_d          = k_q;
    req_idx_d    = req_idx_q;
    s_dat_d      = s_dat_q;
    s_ack_d      = 1'b0;
    m_adr_d      = m_adr_q;
    m_dat_d      = m_dat_q;
    m_sel_d      = m_sel_q;
    m_stb_d      = m_stb_q;
    m_cyc_d      = m_cyc_q;
    m_we_d       = m_we_q;
    line_we_c    = 1'b0;
    hit_inc_c    = 1'b0;
    miss_inc_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) valid_d = 1'b0;
        if (req_c) begin
          if (s_wb_we_i) begin
            m_adr_d = s_wb_adr_i;
            m_dat_d = s_wb_dat_i;
            m_sel_d = s_wb_sel_i;
            m_we_d  = 1'b1;
            m_cyc_d = 1'b1;
            m_stb_d = 1'b1;
            valid_d = 1'b0;
          end else if (hit_c) begin
            s_dat_d   = line_q[req_idx_c];
            s_ack_d   = 1'b1;
            hit_inc_c = 1'b1;
          end else begin
            tag_d        = req_tag_c;
            req_idx_d    = req_idx_c;
            valid_d      = 1'b0;
            flush_pend_d = 1'b0;
            gap_d        = 1'b0;
            k_d          = '0;
            m_adr_d      = {req_tag_c, {IDX_W{1'b0}}, 2'b00};
            m_sel_d      = 4'hF;
            m_we_d       = 1'b0;
            m_cyc_d      = 1'b1;
            m_stb_d      = 1'b1;
          end
        end
      end
      FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (gap_q) begin
          m_stb_d = 1'b1;
          m_adr_d = {tag_q, k_q, 2'b00};
          gap_d   = 1'b0;
        end else if (mack_c) begin
          line_we_c = 1'b1;
          k_d       = k_q + 1'b1;
          m_stb_d   = 1'b0;
          if (last_c) begin
            m_cyc_d      = 1'b0;
            valid_d      = ~(flush_pend_q | flush);
            flush_pend_d = 1'b0;
            s_dat_d      = (req_idx_q == k_q) ? m_wb_dat_i : line_q[req_idx_q];
            s_ack_d      = s_wb_cyc_i;
            miss_inc_c   = 1'b1;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (m_wb_ack_i) begin
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          s_ack_d = s_wb_cyc_i;
        end
      end
      ACK: if (flush) valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      gap_q        <= 1'b0;
      tag_q        <= '0;
      k_q          <= '0;
      req_idx_q    <= '0;
      s_dat_q      <= '0;
      s_ack_q      <= 1'b0;
      m_adr_q      <= '0;
      m_dat_q      <= '0;
      m_sel_q      <= '0;
      m_stb_q      <= 1'b0;
      m_cyc_q      <= 1'b0;
      m_we_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      gap_q        <= gap_d;
      tag_q        <= tag_d;
      k_q          <= k_d;
      req_idx_q    <= req_idx_d;
      s_dat_q      <= s_dat_d;
      s_ack_q      <= s_ack_d;
      m_adr_q      <= m_adr_d;
      m_dat_q      <= m_dat_d;
      m_sel_q      <= m_sel_d;
      m_stb_q      <= m_stb_d;
      m_cyc_q      <= m_cyc_d;
      m_we_q       <= m_we_d;
    end
  end

  // Line storage carries no reset; valid_q guards its contents.
  always_ff @(posedge sys_clk) begin
    if (line_we_c) line_q[k_q] <= m_wb_dat_i;
  end

`ifdef NORFLASH_PREFETCH_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc_c)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc_c) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic stats_unused_c;
  assign stats_unused_c = hit_inc_c | miss_inc_c;
`endif

  assign s_wb_dat_o = s_dat_q;
  assign s_wb_ack_o = s_ack_q;
  assign m_wb_adr_o = m_adr_q;
  assign m_wb_dat_o = m_dat_q;
  assign m_wb_sel_o = m_sel_q;
  assign m_wb_stb_o = m_stb_q;
  assign m_wb_cyc_o = m_cyc_q;
  assign m_wb_we_o  = m_we_q;

endmodule
